// File: rtl/mux_sel_arbiter.sv
// Round-robin 4-source arbiter that drives the select code of a downstream mux4.
// Grants are held until done, request drop, or a MAX_HOLD-cycle tenure limit.
module mux_sel_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] Sel,
  output logic [3:0] gnt,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    sel_d;
  logic [3:0]    gnt_d;
  logic          valid_d;
  logic          timeout_d;

  logic [1:0]    arb_ptr;
  logic [2:0]    win;
  logic          at_limit;
  logic          release_c;
  logic          rearb;

  // Returns {found, index} of the first request at or after p, wrapping 3->0.
  // Scanning from owner+1 visits the old owner last, so it only wins when alone.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    pick = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) pick = {1'b1, idx};
    end
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    sel_d     = Sel;
    gnt_d     = gnt;
    valid_d   = gnt_valid;
    timeout_d = 1'b0;

    at_limit  = (hold_q == HOLD_LAST);
    release_c = done | ~req[Sel] | at_limit;
    rearb     = (state_q == IDLE) | release_c;
    arb_ptr   = (state_q == BUSY) ? Sel + 2'd1 : ptr_q;
    win       = pick(req, arb_ptr);

    if (rearb) begin
      ptr_d     = arb_ptr;
      timeout_d = (state_q == BUSY) & at_limit & ~done & req[Sel];
      hold_d    = '0;
      if (win[2]) begin
        state_d = BUSY;
        sel_d   = win[1:0];
        gnt_d   = 4'b0001 << win[1:0];
        valid_d = 1'b1;
      end else begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        valid_d = 1'b0;
      end
    end else begin
      hold_d = hold_q + HW'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      hold_q    <= '0;
      Sel       <= 2'b00;
      gnt       <= 4'b0000;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      Sel       <= sel_d;
      gnt       <= gnt_d;
      gnt_valid <= valid_d;
      timeout   <= timeout_d;
    end
  end

endmodule
